// File: rtl/regfile_scoreboard_if.sv
// Register-file/scoreboard bus: read ports, issue, write-back, kill and flush events.
// The master drives the pipeline events and the slave is the register file.
interface regfile_scoreboard_if #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32,
  parameter int NRD   = 2
);
  localparam int AW = $clog2(NREGS);

  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                iss_valid;
  logic [AW-1:0]       iss_rd;
  logic                iss_ready;
  logic                wb_valid;
  logic [AW-1:0]       wb_rd;
  logic [XLEN-1:0]     wb_data;
  logic                kill_valid;
  logic [AW-1:0]       kill_rd;
  logic                flush_all;
  logic                pend_any;
  logic                err_underflow;

  modport master (
    output rd_addr, iss_valid, iss_rd, wb_valid, wb_rd, wb_data,
           kill_valid, kill_rd, flush_all,
    input  rd_data, rd_busy, iss_ready, pend_any, err_underflow
  );

  modport slave (
    input  rd_addr, iss_valid, iss_rd, wb_valid, wb_rd, wb_data,
           kill_valid, kill_rd, flush_all,
    output rd_data, rd_busy, iss_ready, pend_any, err_underflow
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Register file with write-first bypass, hardwired zero register and per-register
// pending-write counters so decode can stall on RAW hazards.
module regfile_scoreboard #(
  parameter int XLEN     = 64,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int PEND_W   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_scoreboard_if.slave  bus
);
  localparam int AW = $clog2(NREGS);
  localparam logic [PEND_W-1:0] CNT_MAX = '1;

  logic [XLEN-1:0]   r_regs [NREGS];
  logic [PEND_W-1:0] r_cnt  [NREGS];
  logic              r_pend_any;
  logic              r_err;

  logic [PEND_W-1:0] w_cnt_next [NREGS];
  logic [NREGS-1:0]  w_under;
  logic              w_any_next;
  logic              w_iss_zero;
  logic              w_wb_zero;
  logic              w_iss_dec;
  logic              w_iss_ready;
  logic              w_inc;
  logic              w_dwb;
  logic              w_dk;
  logic [PEND_W:0]   w_add;
  logic [PEND_W:0]   w_dec;
  logic [PEND_W:0]   w_diff;

  assign w_iss_zero = (ZERO_REG != 0) && (bus.iss_rd == '0);
  assign w_wb_zero  = (ZERO_REG != 0) && (bus.wb_rd == '0);

  // A saturated counter can still accept an issue when a same-cycle retire frees a slot.
  assign w_iss_dec   = (bus.wb_valid && (bus.wb_rd == bus.iss_rd)) ||
                       (bus.kill_valid && (bus.kill_rd == bus.iss_rd));
  assign w_iss_ready = w_iss_zero || !((r_cnt[bus.iss_rd] == CNT_MAX) && !w_iss_dec);

  always_comb begin
    w_any_next = 1'b0;
    w_under    = '0;
    w_inc      = 1'b0;
    w_dwb      = 1'b0;
    w_dk       = 1'b0;
    w_add      = '0;
    w_dec      = '0;
    w_diff     = '0;
    for (int r = 0; r < NREGS; r++) begin
      w_inc = bus.iss_valid && w_iss_ready && (bus.iss_rd == AW'(r));
      w_dwb = bus.wb_valid && (bus.wb_rd == AW'(r));
      w_dk  = bus.kill_valid && (bus.kill_rd == AW'(r));
      if ((ZERO_REG != 0) && (r == 0)) begin
        w_inc = 1'b0;
        w_dwb = 1'b0;
        w_dk  = 1'b0;
      end
      w_add  = {1'b0, r_cnt[r]} + (PEND_W+1)'(w_inc);
      w_dec  = (PEND_W+1)'(w_dwb) + (PEND_W+1)'(w_dk);
      w_diff = w_add - w_dec;
      w_under[r] = (w_dec > w_add);
      w_cnt_next[r] = w_under[r] ? '0 : w_diff[PEND_W-1:0];
      w_any_next = w_any_next || (w_cnt_next[r] != '0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) begin
        r_regs[r] <= '0;
        r_cnt[r]  <= '0;
      end
      r_pend_any <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      if (bus.wb_valid && !w_wb_zero) begin
        r_regs[bus.wb_rd] <= bus.wb_data;
      end
      for (int r = 0; r < NREGS; r++) begin
        r_cnt[r] <= bus.flush_all ? '0 : w_cnt_next[r];
      end
      r_pend_any <= w_any_next && !bus.flush_all;
      if (!bus.flush_all && (w_under != '0)) begin
        r_err <= 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NRD; gi++) begin : g_rd
      logic [AW-1:0] w_raddr;
      logic          w_rzero;
      assign w_raddr = bus.rd_addr[gi*AW +: AW];
      assign w_rzero = (ZERO_REG != 0) && (w_raddr == '0);
      assign bus.rd_data[gi*XLEN +: XLEN] =
          w_rzero                                   ? '0          :
          (bus.wb_valid && (bus.wb_rd == w_raddr))  ? bus.wb_data :
                                                      r_regs[w_raddr];
      // Busy reflects the post-edge count, so a bypassed final write-back is not a hazard.
      assign bus.rd_busy[gi] = !w_rzero && (w_cnt_next[w_raddr] != '0);
    end
  endgenerate

  assign bus.iss_ready     = w_iss_ready;
  assign bus.pend_any      = r_pend_any;
  assign bus.err_underflow = r_err;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed-vector bench for regfile_scoreboard with hand-computed expectations.
module tb_regfile_scoreboard;
  localparam int XLEN  = 64;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  regfile_scoreboard_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) bus ();

  regfile_scoreboard #(
    .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .PEND_W(2), .ZERO_REG(1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    bus.iss_valid  = 1'b0;
    bus.iss_rd     = '0;
    bus.wb_valid   = 1'b0;
    bus.wb_rd      = '0;
    bus.wb_data    = '0;
    bus.kill_valid = 1'b0;
    bus.kill_rd    = '0;
    bus.flush_all  = 1'b0;
  endtask

  function automatic logic [63:0] rd0();
    return bus.rd_data[0 +: XLEN];
  endfunction

  function automatic logic [63:0] rd1();
    return bus.rd_data[XLEN +: XLEN];
  endfunction

  task automatic set_addr(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    bus.rd_addr = {a1, a0};
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    idle();
    set_addr(5'd0, 5'd0);
    #12;
    check("rst_rd0", rd0(), 64'h0);
    check("rst_busy", bus.rd_busy, 2'b00);
    check("rst_pend", bus.pend_any, 1'b0);
    check("rst_err", bus.err_underflow, 1'b0);
    reset = 1'b0;
    step();

    // RAW bypass
    set_addr(5'd5, 5'd0);
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd5;
    #1;
    check("raw_iss_ready", bus.iss_ready, 1'b1);
    check("raw_busy_iss", bus.rd_busy[0], 1'b1);
    step();
    idle();
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd5; bus.wb_data = 64'hDEAD;
    #1;
    check("raw_pend", bus.pend_any, 1'b1);
    check("raw_bypass", rd0(), 64'hDEAD);
    check("raw_busy_wb", bus.rd_busy[0], 1'b0);
    step();
    idle();
    #1;
    check("raw_stored", rd0(), 64'hDEAD);
    check("raw_pend_clr", bus.pend_any, 1'b0);

    // Saturation of x7
    set_addr(5'd0, 5'd7);
    for (int k = 0; k < 3; k++) begin
      bus.iss_valid = 1'b1; bus.iss_rd = 5'd7;
      step();
    end
    #1;
    check("sat_ready0", bus.iss_ready, 1'b0);
    check("sat_busy", bus.rd_busy[1], 1'b1);
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd7; bus.wb_data = 64'h77;
    #1;
    check("sat_ready_wb", bus.iss_ready, 1'b1);
    step();
    idle();
    bus.iss_rd = 5'd7;
    #1;
    check("sat_still3", bus.iss_ready, 1'b0);
    for (int k = 0; k < 3; k++) begin
      bus.wb_valid = 1'b1; bus.wb_rd = 5'd7; bus.wb_data = 64'h100 + 64'(k);
      #1;
      check("sat_drain_busy", bus.rd_busy[1], (k == 2) ? 1'b0 : 1'b1);
      step();
    end
    idle();
    #1;
    check("sat_drained_rd", rd1(), 64'h102);
    check("sat_pend", bus.pend_any, 1'b0);
    check("sat_err", bus.err_underflow, 1'b0);

    // Zero register
    set_addr(5'd0, 5'd0);
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd0; bus.wb_data = 64'h5;
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd0;
    #1;
    check("zero_rd", rd0(), 64'h0);
    check("zero_busy", bus.rd_busy[0], 1'b0);
    check("zero_ready", bus.iss_ready, 1'b1);
    step();
    idle();
    #1;
    check("zero_pend", bus.pend_any, 1'b0);
    check("zero_rd_after", rd0(), 64'h0);

    // Kill and flush
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd3;
    step();
    bus.iss_rd = 5'd4;
    step();
    idle();
    set_addr(5'd3, 5'd4);
    bus.kill_valid = 1'b1; bus.kill_rd = 5'd3;
    #1;
    check("kill_x3_busy", bus.rd_busy[0], 1'b0);
    check("kill_x4_busy", bus.rd_busy[1], 1'b1);
    step();
    idle();
    bus.flush_all = 1'b1;
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd4; bus.wb_data = 64'h9;
    bus.kill_valid = 1'b1; bus.kill_rd = 5'd5;
    #1;
    check("flush_pend_before", bus.pend_any, 1'b1);
    check("flush_bypass", rd1(), 64'h9);
    step();
    idle();
    #1;
    check("flush_pend", bus.pend_any, 1'b0);
    check("flush_x4_rd", rd1(), 64'h9);
    check("flush_busy", bus.rd_busy, 2'b00);
    check("flush_no_err", bus.err_underflow, 1'b0);

    // Underflow
    set_addr(5'd9, 5'd0);
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd9; bus.wb_data = 64'h1234;
    #1;
    check("uf_busy", bus.rd_busy[0], 1'b0);
    check("uf_err_pre", bus.err_underflow, 1'b0);
    step();
    idle();
    #1;
    check("uf_err", bus.err_underflow, 1'b1);
    check("uf_data", rd0(), 64'h1234);
    check("uf_pend", bus.pend_any, 1'b0);
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd2;
    step();
    idle();
    #1;
    check("uf_sticky", bus.err_underflow, 1'b1);
    check("mid_pend", bus.pend_any, 1'b1);

    // Asynchronous reset away from any clock edge
    reset = 1'b1;
    #1;
    check("arst_rd0", rd0(), 64'h0);
    check("arst_busy", bus.rd_busy, 2'b00);
    check("arst_pend", bus.pend_any, 1'b0);
    check("arst_err", bus.err_underflow, 1'b0);
    step();
    reset = 1'b0;
    set_addr(5'd2, 5'd0);
    #1;
    check("arst_x2_busy", bus.rd_busy[0], 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
